// File: rtl/vrf_pkg.sv
// Shared vector register file definitions.
// State encoding and default geometry for the lane writeback path.
package vrf_pkg;

    localparam int VRF_DATA_WIDTH = 32;
    localparam int VRF_REG_NUM    = 32;
    localparam int VRF_ELEMS      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/vrf_wb_fifo.sv
// Result FIFO for the writeback sequencer.
// Extra pointer bit separates full from empty; storage clears on reset.
module vrf_wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointers and storage; reset discards any held results.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/vrf_wb_sequencer.sv
// Lane writeback sequencer: FIFOs ALU results, replays them into the VRF.
// Optional VRF_WB_MASK_EN gates element writes with mask_i.
module vrf_wb_sequencer
    import vrf_pkg::*;
#(
    parameter int DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int REG_NUM    = VRF_REG_NUM,
    parameter int ELEMS      = VRF_ELEMS,
    parameter int FIFO_DEPTH = 4,
    localparam int ADDR_B    = $clog2(REG_NUM),
    localparam int ELEM_B    = $clog2(ELEMS)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  wb_start_i,
    input  logic [ADDR_B-1:0]     wb_addr_i,
    input  logic [ELEM_B:0]       wb_elems_i,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    output logic                  res_ready_o,
    input  logic [DATA_WIDTH-1:0] mask_i,
    output logic                  wr_req_o,
    output logic                  wr_en_o,
    output logic                  wr_ready_o,
    output logic [ADDR_B-1:0]     wr_addr_o,
    output logic [ELEM_B-1:0]     wr_elem_cnt_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ELEM_B:0] CNT_ONE = (ELEM_B + 1)'(1);

    wb_state_t           state_q, state_d;
    logic [ADDR_B-1:0]   addr_q, addr_d;
    logic [ELEM_B:0]     elems_q, elems_d;
    logic [ELEM_B:0]     cnt_q, cnt_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                pop;
    logic                last;
    logic                mask_ok;

    assign fifo_push = res_valid_i && !fifo_full;
    assign pop       = (state_q == WRITE) && !fifo_empty;
    assign last      = (cnt_q == elems_q - CNT_ONE);

    vrf_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (fifo_push),
        .data_i   (res_data_i),
        .pop_i    (pop),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (wdata_o)
    );

`ifdef VRF_WB_MASK_EN
    localparam int MIDX_B = $clog2(DATA_WIDTH);
    logic [MIDX_B-1:0] mask_idx;
    assign mask_idx = MIDX_B'(cnt_q[ELEM_B-1:0]);
    assign mask_ok  = mask_i[mask_idx];
`else
    logic unused_mask;
    assign unused_mask = ^mask_i;
    assign mask_ok     = 1'b1;
`endif

    // Next-state: instruction latch, element counter, FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        elems_d = elems_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (wb_start_i) begin
                    addr_d  = wb_addr_i;
                    elems_d = wb_elems_i;
                    cnt_d   = '0;
                    state_d = (wb_elems_i == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                state_d = WRITE;
            end
            WRITE: begin
                if (pop) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            elems_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            elems_q <= elems_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_ready_o   = !fifo_full;
    assign wr_req_o      = (state_q == REQ);
    assign wr_en_o       = pop && mask_ok;
    assign wr_ready_o    = pop && last;
    assign wr_addr_o     = addr_q;
    assign wr_elem_cnt_o = cnt_q[ELEM_B-1:0];
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_vrf_wb_sequencer.sv
// Bench for vrf_wb_sequencer: per-cycle vector table plus reset sequence.
// Build with VRF_WB_MASK_EN to exercise masked writes.
module tb_vrf_wb_sequencer;

`ifdef VRF_WB_MASK_EN
    localparam int MK = 1;
`else
    localparam int MK = 0;
`endif
    localparam int NM = 1 - MK;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_start;
    logic [4:0]  wb_addr;
    logic [2:0]  wb_elems;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic [31:0] mask;
    logic        wr_req;
    logic        wr_en;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [1:0]  wr_cnt;
    logic [31:0] wdata;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vrf_wb_sequencer dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .wb_start_i    (wb_start),
        .wb_addr_i     (wb_addr),
        .wb_elems_i    (wb_elems),
        .res_valid_i   (res_valid),
        .res_data_i    (res_data),
        .res_ready_o   (res_ready),
        .mask_i        (mask),
        .wr_req_o      (wr_req),
        .wr_en_o       (wr_en),
        .wr_ready_o    (wr_ready),
        .wr_addr_o     (wr_addr),
        .wr_elem_cnt_o (wr_cnt),
        .wdata_o       (wdata),
        .busy_o        (busy),
        .done_o        (done)
    );

    typedef struct {
        int st; int a; int el; int rv; int rd; int m;
        int req; int en; int rdy; int dn; int bsy; int rr;
        int cw; int cnt; int ea;
        int cd; int d;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input int st, input int a, input int el,
        input int rv, input int rd, input int m,
        input int req, input int en, input int rdy,
        input int dn, input int bsy, input int rr,
        input int cw, input int cnt, input int ea,
        input int cd, input int d
    );
        vec_t v;
        v.st = st; v.a = a; v.el = el;
        v.rv = rv; v.rd = rd; v.m = m;
        v.req = req; v.en = en; v.rdy = rdy;
        v.dn = dn; v.bsy = bsy; v.rr = rr;
        v.cw = cw; v.cnt = cnt; v.ea = ea;
        v.cd = cd; v.d = d;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        @(negedge clk);
        wb_start  = v.st[0];
        wb_addr   = 5'(v.a);
        wb_elems  = 3'(v.el);
        res_valid = v.rv[0];
        res_data  = v.rd;
        mask      = v.m;
        #1;
        chk("req", i, 32'(wr_req), v.req);
        chk("en", i, 32'(wr_en), v.en);
        chk("ready", i, 32'(wr_ready), v.rdy);
        chk("done", i, 32'(done), v.dn);
        chk("busy", i, 32'(busy), v.bsy);
        chk("res_ready", i, 32'(res_ready), v.rr);
        if (v.cw != 0) begin
            chk("cnt", i, 32'(wr_cnt), v.cnt);
            chk("addr", i, 32'(wr_addr), v.ea);
        end
        if (v.cd != 0) chk("wdata", i, wdata, v.d);
    endtask

    localparam int F = 32'hFFFF_FFFF;

    initial begin
        resetn = 1'b1; wb_start = 0; wb_addr = 0; wb_elems = 0;
        res_valid = 0; res_data = 0; mask = F;
        #2 resetn = 1'b0;
        #1;
        chk("rst_req", 0, 32'(wr_req), 0);
        chk("rst_en", 0, 32'(wr_en), 0);
        chk("rst_ready", 0, 32'(wr_ready), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_addr", 0, 32'(wr_addr), 0);
        chk("rst_cnt", 0, 32'(wr_cnt), 0);
        chk("rst_wdata", 0, wdata, 0);
        chk("rst_rr", 0, 32'(res_ready), 1);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        // preload 4, start addr 5 elems 4
        add(0,0,0, 1,'h11,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'h22,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'h33,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'h44,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(1,5,4, 0,0,F,    0,0,0,0,0,0, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    1,0,0,0,1,0, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,1,0,0,1,0, 1,0,5, 1,'h11);
        add(0,0,0, 0,0,F,    0,1,0,0,1,1, 1,1,5, 1,'h22);
        add(0,0,0, 0,0,F,    0,1,0,0,1,1, 1,2,5, 1,'h33);
        add(0,0,0, 0,0,F,    0,1,1,0,1,1, 1,3,5, 1,'h44);
        add(0,0,0, 0,0,F,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        // elems 0: straight to DONE
        add(1,3,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        // 5 pushes into a 4-deep FIFO
        add(0,0,0, 1,'hA1,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hA2,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hA3,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hA4,F, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hA5,F, 0,0,0,0,0,0, 0,0,0, 0,0);
        add(1,7,4, 1,'hA5,F, 0,0,0,0,0,0, 0,0,0, 0,0);
        add(0,0,0, 1,'hA5,F, 1,0,0,0,1,0, 0,0,0, 0,0);
        add(0,0,0, 1,'hA5,F, 0,1,0,0,1,0, 1,0,7, 1,'hA1);
        add(0,0,0, 1,'hA5,F, 0,1,0,0,1,1, 1,1,7, 1,'hA2);
        add(0,0,0, 0,0,F,    0,1,0,0,1,1, 1,2,7, 1,'hA3);
        add(0,0,0, 0,0,F,    0,1,1,0,1,1, 1,3,7, 1,'hA4);
        add(0,0,0, 0,0,F,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 1,'hA5);
        // elems 1 drains the held 5th result
        add(1,2,1, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    1,0,0,0,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,1,1,0,1,1, 1,0,2, 1,'hA5);
        add(0,0,0, 0,0,F,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        // elems 3 with results every other cycle
        add(1,9,3, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hB0,F, 1,0,0,0,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,1,0,0,1,1, 1,0,9, 1,'hB0);
        add(0,0,0, 1,'hB1,F, 0,0,0,0,1,1, 1,1,9, 0,0);
        add(0,0,0, 0,0,F,    0,1,0,0,1,1, 1,1,9, 1,'hB1);
        add(0,0,0, 1,'hB2,F, 0,0,0,0,1,1, 1,2,9, 0,0);
        add(0,0,0, 0,0,F,    0,1,1,0,1,1, 1,2,9, 1,'hB2);
        add(0,0,0, 0,0,F,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);
        // mask 0b0101, elems 4
        add(0,0,0, 1,'hC0,5, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hC1,5, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hC2,5, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(0,0,0, 1,'hC3,5, 0,0,0,0,0,1, 0,0,0, 0,0);
        add(1,1,4, 0,0,5,    0,0,0,0,0,0, 0,0,0, 0,0);
        add(0,0,0, 0,0,5,    1,0,0,0,1,0, 0,0,0, 0,0);
        add(0,0,0, 0,0,5,    0,1,0,0,1,0, 1,0,1, 1,'hC0);
        add(0,0,0, 0,0,5,    0,NM,0,0,1,1, 1,1,1, 1,'hC1);
        add(0,0,0, 0,0,5,    0,1,0,0,1,1, 1,2,1, 1,'hC2);
        add(0,0,0, 0,0,5,    0,NM,1,0,1,1, 1,3,1, 1,'hC3);
        add(0,0,0, 0,0,5,    0,0,0,1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,F,    0,0,0,0,0,1, 0,0,0, 0,0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset in the middle of a 4-element instruction
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            res_valid = 1'b1; res_data = 32'hD1 + 32'(k);
        end
        @(negedge clk);
        res_valid = 1'b0; wb_start = 1'b1; wb_addr = 5'd6; wb_elems = 3'd4;
        @(negedge clk);
        wb_start = 1'b0;
        #1 chk("mr_req", 100, 32'(wr_req), 1);
        @(negedge clk);
        #1 chk("mr_w0", 101, wdata, 32'hD1);
        chk("mr_en0", 101, 32'(wr_en), 1);
        @(negedge clk);
        #1 chk("mr_w1", 102, wdata, 32'hD2);
        chk("mr_cnt1", 102, 32'(wr_cnt), 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mr_req0", 103, 32'(wr_req), 0);
        chk("mr_en0", 103, 32'(wr_en), 0);
        chk("mr_rdy0", 103, 32'(wr_ready), 0);
        chk("mr_done0", 103, 32'(done), 0);
        chk("mr_busy0", 103, 32'(busy), 0);
        chk("mr_addr0", 103, 32'(wr_addr), 0);
        chk("mr_cnt0", 103, 32'(wr_cnt), 0);
        chk("mr_wdata0", 103, wdata, 0);
        chk("mr_rr", 103, 32'(res_ready), 1);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'hE0;
        wb_start = 1'b1; wb_addr = 5'd4; wb_elems = 3'd1;
        #1 chk("pr_busy", 104, 32'(busy), 0);
        @(negedge clk);
        res_valid = 1'b0; wb_start = 1'b0;
        #1 chk("pr_req", 105, 32'(wr_req), 1);
        @(negedge clk);
        #1 chk("pr_en", 106, 32'(wr_en), 1);
        chk("pr_cnt", 106, 32'(wr_cnt), 0);
        chk("pr_wdata", 106, wdata, 32'hE0);
        chk("pr_rdy", 106, 32'(wr_ready), 1);
        chk("pr_addr", 106, 32'(wr_addr), 4);
        @(negedge clk);
        #1 chk("pr_done", 107, 32'(done), 1);
        @(negedge clk);
        #1 chk("pr_idle", 108, 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
